// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer (master) and the multi-cycle datapath (slave).
// The counter width must match the CNT_W of the connected stage_sequencer.
interface stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             rwmem;
  logic             exaluEnable;
  logic             exBusy;
  logic             memWait;
  logic             halt_req;
  logic             step_req;
  logic             en_ft;
  logic             en_dc;
  logic             en_ex;
  logic             en_ma;
  logic             en_wb;
  logic [3:0]       stage;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  rwmem, exaluEnable, exBusy, memWait, halt_req, step_req,
    output en_ft, en_dc, en_ex, en_ma, en_wb, stage, halted, bus_err,
    output cycle_cnt, instret_cnt, stall_cnt
  );

  modport slave (
    output rwmem, exaluEnable, exBusy, memWait, halt_req, step_req,
    input  en_ft, en_dc, en_ex, en_ma, en_wb, stage, halted, bus_err,
    input  cycle_cnt, instret_cnt, stall_cnt
  );
endinterface

// File: rtl/stage_sequencer.sv
// Single-clock stage sequencer for the multi-cycle RV32 core: one-cycle stage enables,
// memory-wait watchdog, debug halt/step. Define STAGE_PERF_CNT_EN to build the perf counters.
module stage_sequencer #(
  parameter int MEM_TIMEOUT = 1023,
  parameter int CNT_W       = 32
) (
  input logic              CLK,
  input logic              RST,
  stage_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FT   = 4'd1,
    S_DC   = 4'd2,
    S_EX   = 4'd3,
    S_EXW  = 4'd4,
    S_MA   = 4'd5,
    S_MAW  = 4'd6,
    S_WB   = 4'd7,
    S_HALT = 4'd8,
    S_ERR  = 4'd9
  } state_t;

  // The wait counter only has to reach MEM_TIMEOUT-1: the next high cycle trips the watchdog.
  localparam int WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t            state_reg, state_next;
  logic              rwmem_lat_reg;
  logic              exw_first_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      rwmem_lat_reg <= 1'b0;
      exw_first_reg <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      exw_first_reg <= (state_reg == S_EX);
      if (state_reg == S_EX)
        rwmem_lat_reg <= bus.rwmem;
      if (state_reg == S_MA)
        wait_cnt_reg <= '0;
      else if (state_reg == S_MAW && bus.memWait)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_FT;
      S_FT:   state_next = S_DC;
      S_DC:   state_next = S_EX;
      S_EX: begin
        if (bus.exaluEnable)
          state_next = S_EXW;
        else if (bus.rwmem)
          state_next = S_MA;
        else
          state_next = S_WB;
      end
      // The exalu only raises busy one cycle after its strobe, so the first EXW cycle is blind.
      S_EXW: begin
        if (!exw_first_reg && !bus.exBusy)
          state_next = rwmem_lat_reg ? S_MA : S_WB;
      end
      S_MA:   state_next = S_MAW;
      S_MAW: begin
        if (!bus.memWait)
          state_next = S_WB;
        else if (MEM_TIMEOUT != 0 && wait_cnt_reg == WAIT_W'(TO_LAST))
          state_next = S_ERR;
      end
      S_WB:   state_next = bus.halt_req ? S_HALT : S_FT;
      S_HALT: begin
        if (!bus.halt_req || bus.step_req)
          state_next = S_FT;
      end
      S_ERR:  state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.en_ft   = (state_reg == S_FT);
    bus.en_dc   = (state_reg == S_DC);
    bus.en_ex   = (state_reg == S_EX);
    bus.en_ma   = (state_reg == S_MA);
    bus.en_wb   = (state_reg == S_WB);
    bus.stage   = state_reg;
    bus.halted  = (state_reg == S_HALT) || (state_reg == S_ERR);
    bus.bus_err = (state_reg == S_ERR);
  end

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg, stall_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      if (state_reg != S_HALT && state_reg != S_ERR)
        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (state_reg == S_WB)
        instret_cnt_reg <= instret_cnt_reg + 1'b1;
      if ((state_reg == S_EXW && !exw_first_reg) || (state_reg == S_MAW && bus.memWait))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_reg;
  assign bus.instret_cnt = instret_cnt_reg;
  assign bus.stall_cnt   = stall_cnt_reg;
`else
  assign bus.cycle_cnt   = '0;
  assign bus.instret_cnt = '0;
  assign bus.stall_cnt   = '0;
`endif

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Synchronous replacement for the multi-phase clock generator of the multi-cycle RV32 core.
- Runs on the single core clock and issues one-cycle stage-enable pulses (fetch, decode, execute, memory, writeback) that the datapath uses as clock enables.
- Skips the memory stage for non-memory instructions and stalls on wide-ALU busy and MMU wait.
- Adds a memory-wait watchdog and debug halt/single-step.

Parameters:
- MEM_TIMEOUT, 1023: consecutive memWait-high cycles in MAW before bus error; 0 disables the watchdog.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  input  1  core clock
- RST  input  1  synchronous active-high reset
- rwmem  input  1  decoded instruction uses the memory stage; sampled in EX
- exaluEnable  input  1  decoded instruction uses the 256-bit exalu; sampled in EX
- exBusy  input  1  exalu busy
- memWait  input  1  MMU stall request
- halt_req  input  1  debug halt request (level)
- step_req  input  1  single-step pulse, honoured only in HALT
- en_ft  output  1  fetch enable pulse
- en_dc  output  1  decode / register-read enable pulse
- en_ex  output  1  execute enable pulse; exalu write strobe is en_ex & exaluEnable
- en_ma  output  1  memory-access enable pulse
- en_wb  output  1  writeback / PC-update enable pulse
- stage  output  4  state code: IDLE=0, FT=1, DC=2, EX=3, EXW=4, MA=5, MAW=6, WB=7, HALT=8, ERR=9
- halted  output  1  high in HALT or ERR
- bus_err  output  1  sticky watchdog error
- cycle_cnt  output  CNT_W  performance counter
- instret_cnt  output  CNT_W  performance counter
- stall_cnt  output  CNT_W  performance counter

Behaviour:
- Reset (any state, any cycle): next state IDLE; all outputs 0; wait counter and performance counters cleared. An access in progress is abandoned with no further enables.
- Outputs are Moore, registered from state. Each en_x is high exactly for the one cycle the FSM is in the matching state. Wait states produce no enables.
- IDLE -> FT.
- FT -> DC.
- DC -> EX.
- EX: if exaluEnable -> EXW; else if rwmem -> MA; else -> WB.
- EXW:
  - First cycle ignores exBusy; exalu raises busy within one cycle of its strobe.
  - From the second cycle, exBusy==0 -> MA if rwmem was latched in EX, else WB.
  - Minimum 2 cycles; no timeout.
- MA -> MAW; the wait counter is cleared on entry to MAW.
- MAW:
  - memWait==0 -> WB.
  - memWait==1: increment the counter.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with memWait still high -> ERR. ERR is entered the cycle after the MEM_TIMEOUT-th consecutive high cycle.
- WB: halt_req==1 -> HALT; else -> FT.
- HALT:
  - halted=1.
  - halt_req==0 -> FT.
  - step_req==1 -> FT (executes one instruction, then re-halts at WB if halt_req is still high).
  - step_req outside HALT is ignored.
- ERR: bus_err=1, halted=1; exits only on RST.
- halt_req asserted mid-instruction takes effect only at the WB boundary; the instruction always completes.
- rwmem and exaluEnable are latched in EX and held until WB, so later input changes have no effect.
- Latency, no stalls:
  - ALU or branch instruction: FT, DC, EX, WB = 4 cycles.
  - Load or store: FT, DC, EX, MA, MAW, WB = 6 cycles.
  - exalu instruction, busy 1 cycle: 6 cycles.
  - First FT occurs 1 cycle after RST deasserts.

Optional Feature:
STAGE_PERF_CNT_EN
- Defined:
  - cycle_cnt increments every cycle the state is not HALT or ERR.
  - instret_cnt increments on each WB cycle.
  - stall_cnt increments on each EXW cycle after the first, and on each MAW cycle with memWait=1.
  - All counters wrap modulo 2^CNT_W and clear on RST.
- Undefined: the three counter ports remain and are tied to 0; no counter flops are built.

Test Plan:
- Release RST, hold rwmem=0, exaluEnable=0, halt_req=0 -> stage sequence 0,1,2,3,7,1,2,3,7…; en_wb pulses every 4 cycles; instret_cnt=3 after 3 WB cycles.
- rwmem=1, memWait high for 3 MAW cycles -> MAW occupies 4 cycles; en_wb follows; instruction takes 9 cycles; stall_cnt=3.
- exaluEnable=1, rwmem=1, exBusy high 4 cycles after en_ex -> EX, EXW×5, MA, MAW, WB in order; exactly one en_ma pulse.
- MEM_TIMEOUT=8, memWait held high -> ERR (stage=9) the cycle after the 8th MAW cycle; bus_err=1 and sticky; en_* stay 0 until RST, then restart from IDLE.
- halt_req raised during DC -> EX and WB complete, then HALT, halted=1. One step_req pulse -> exactly one FT…WB pass, then HALT again; cycle_cnt frozen while halted.
- RST asserted during MAW with memWait=1 -> next cycle stage=0, all outputs and counters 0, no en_wb issued.
